// File: rtl/popcount_seq_pkg.sv
// ---------------------------------------------------------------------------
// popcount_seq_pkg
//   Shared definitions for the sequential popcount block:
//     - state_t    : FSM state encoding (IDLE / BUSY / DONE)
//     - calc_cw    : width needed to hold a count of 0..width
//     - calc_nchunk: number of CHUNK-bit slices needed to cover a word
// ---------------------------------------------------------------------------
package popcount_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bits required to represent any count from 0 to width inclusive.
  function automatic int calc_cw(input int width);
    return $clog2(width + 1);
  endfunction

  // Ceiling division: chunks needed to cover width bits.
  function automatic int calc_nchunk(input int width, input int chunk);
    return (width + chunk - 1) / chunk;
  endfunction

endpackage

// File: rtl/popcount_seq_chunk.sv
// ---------------------------------------------------------------------------
// popcount_chunk
//   Combinational ones-counter for a single CHUNK-bit slice. Only bits whose
//   mask bit is set contribute, so the caller can exclude padding positions.
//   Ports:
//     i_bits  [CHUNK-1:0]        slice to count (already inverted if needed)
//     i_mask  [CHUNK-1:0]        1 = bit position is part of the real word
//     o_count [clog2(CHUNK+1)-1:0] number of set, unmasked bits
// ---------------------------------------------------------------------------
module popcount_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0]             i_bits,
  input  logic [CHUNK-1:0]             i_mask,
  output logic [$clog2(CHUNK+1)-1:0]   o_count
);

  localparam int CCW = $clog2(CHUNK + 1);

  logic [CHUNK-1:0] w_live;

  assign w_live = i_bits & i_mask;

  always_comb begin
    o_count = '0;
    for (int i = 0; i < CHUNK; i++) begin
      o_count = o_count + CCW'(w_live[i]);
    end
  end

endmodule

// File: rtl/popcount_seq.sv
// ---------------------------------------------------------------------------
// popcount_seq
//   Multi-cycle ones/zeros counter. A WIDTH-bit word is accepted over a
//   valid/ready handshake, counted CHUNK bits per clock, and the result is
//   offered over a second valid/ready handshake. Every delivered count is
//   added to a saturating running total with a sticky saturation flag.
//   Ports:
//     clk, rst              clock (rising edge), async active-high reset
//     in_valid/in_ready     input handshake
//     in_bits [WIDTH-1:0]   word to count
//     in_mode               0 = count ones, 1 = count zeros (latched with word)
//     out_valid/out_ready   output handshake
//     out_count [CW-1:0]    per-word count, valid only while out_valid=1
//     acc_clr               synchronous clear of the running total
//     acc_total [ACC_W-1:0] saturating running total
//     acc_sat               sticky: running total has clamped
// ---------------------------------------------------------------------------
module popcount_seq
  import popcount_seq_pkg::*;
#(
  parameter int WIDTH = 12,
  parameter int CHUNK = 4,
  parameter int ACC_W = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_bits,
  input  logic                           in_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [calc_cw(WIDTH)-1:0]      out_count,
  input  logic                           acc_clr,
  output logic [ACC_W-1:0]               acc_total,
  output logic                           acc_sat
);

  localparam int CW        = calc_cw(WIDTH);
  localparam int NCHUNK    = calc_nchunk(WIDTH, CHUNK);
  localparam int PAD_W     = NCHUNK * CHUNK;
  localparam int LAST_BITS = WIDTH - (NCHUNK - 1) * CHUNK;
  localparam int IDX_W     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CCW       = $clog2(CHUNK + 1);

  // State and datapath registers
  state_t             r_state;
  state_t             w_state_next;
  logic [PAD_W-1:0]   r_word;
  logic               r_mode;
  logic [IDX_W-1:0]   r_idx;
  logic [CW-1:0]      r_count;
  logic [ACC_W-1:0]   r_acc;
  logic               r_sat;

  // Chunk selection and counting
  logic [CHUNK-1:0]   w_chunks [NCHUNK];
  logic [CHUNK-1:0]   w_chunk;
  logic [CHUNK-1:0]   w_chunk_in;
  logic [CHUNK-1:0]   w_last_mask;
  logic [CHUNK-1:0]   w_mask;
  logic [CCW-1:0]     w_chunk_cnt;
  logic               w_last;

  // Accumulator arithmetic
  logic               w_out_hs;
  logic [ACC_W-1:0]   w_acc_base;
  logic [ACC_W:0]     w_acc_sum;
  logic               w_acc_ovf;

  // Slice the zero-padded word into chunks.
  for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_chunks
    assign w_chunks[gi] = r_word[gi*CHUNK +: CHUNK];
  end

  // Positions beyond WIDTH in the final chunk are padding; they would read
  // as ones in zeros mode after inversion, so they are masked off here.
  for (genvar gi = 0; gi < CHUNK; gi++) begin : g_last_mask
    assign w_last_mask[gi] = (gi < LAST_BITS);
  end

  assign w_last     = (r_idx == IDX_W'(NCHUNK - 1));
  assign w_chunk    = w_chunks[r_idx];
  assign w_chunk_in = r_mode ? ~w_chunk : w_chunk;
  assign w_mask     = w_last ? w_last_mask : {CHUNK{1'b1}};

  popcount_chunk #(
    .CHUNK (CHUNK)
  ) u_chunk (
    .i_bits  (w_chunk_in),
    .i_mask  (w_mask),
    .o_count (w_chunk_cnt)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Word capture, chunk index and working count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_word  <= '0;
      r_mode  <= 1'b0;
      r_idx   <= '0;
      r_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_word  <= PAD_W'(in_bits);
            r_mode  <= in_mode;
            r_idx   <= '0;
            r_count <= '0;
          end
        end
        ST_BUSY: begin
          r_count <= r_count + CW'(w_chunk_cnt);
          if (!w_last) begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A clear coinciding with a handshake restarts the total from this count,
  // so the clear is folded into the addend base instead of being a priority.
  assign w_out_hs   = (r_state == ST_DONE) && out_ready;
  assign w_acc_base = acc_clr ? '0 : r_acc;
  assign w_acc_sum  = {1'b0, w_acc_base} + (ACC_W+1)'(r_count);
  assign w_acc_ovf  = w_acc_sum[ACC_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end else if (w_out_hs) begin
      r_acc <= w_acc_ovf ? {ACC_W{1'b1}} : w_acc_sum[ACC_W-1:0];
      r_sat <= (r_sat & ~acc_clr) | w_acc_ovf;
    end else if (acc_clr) begin
      r_acc <= '0;
      r_sat <= 1'b0;
    end
  end

  assign out_count = (r_state == ST_DONE) ? r_count : '0;
  assign acc_total = r_acc;
  assign acc_sat   = r_sat;

endmodule

// File: tb/tb_popcount_seq.sv
// ---------------------------------------------------------------------------
// tb_popcount_seq
//   Directed bench for popcount_seq. Three instances cover the default
//   geometry (A: 12/4/16), a padded last chunk (B: 10/4/16) and a narrow
//   accumulator (C: 12/4/4).
// ---------------------------------------------------------------------------
module tb_popcount_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Instance A: WIDTH=12, CHUNK=4, ACC_W=16
  logic        a_in_valid = 1'b0, a_in_mode = 1'b0, a_out_ready = 1'b0, a_acc_clr = 1'b0;
  logic [11:0] a_in_bits  = '0;
  logic        a_in_ready, a_out_valid, a_acc_sat;
  logic [3:0]  a_out_count;
  logic [15:0] a_acc_total;

  // Instance B: WIDTH=10, CHUNK=4, ACC_W=16
  logic        b_in_valid = 1'b0, b_in_mode = 1'b0, b_out_ready = 1'b0, b_acc_clr = 1'b0;
  logic [9:0]  b_in_bits  = '0;
  logic        b_in_ready, b_out_valid, b_acc_sat;
  logic [3:0]  b_out_count;
  logic [15:0] b_acc_total;

  // Instance C: WIDTH=12, CHUNK=4, ACC_W=4
  logic        c_in_valid = 1'b0, c_in_mode = 1'b0, c_out_ready = 1'b0, c_acc_clr = 1'b0;
  logic [11:0] c_in_bits  = '0;
  logic        c_in_ready, c_out_valid, c_acc_sat;
  logic [3:0]  c_out_count;
  logic [3:0]  c_acc_total;

  popcount_seq #(.WIDTH(12), .CHUNK(4), .ACC_W(16)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_bits(a_in_bits), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .acc_clr(a_acc_clr), .acc_total(a_acc_total), .acc_sat(a_acc_sat)
  );

  popcount_seq #(.WIDTH(10), .CHUNK(4), .ACC_W(16)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_bits(b_in_bits), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .acc_clr(b_acc_clr), .acc_total(b_acc_total), .acc_sat(b_acc_sat)
  );

  popcount_seq #(.WIDTH(12), .CHUNK(4), .ACC_W(4)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_bits(c_in_bits), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count),
    .acc_clr(c_acc_clr), .acc_total(c_acc_total), .acc_sat(c_acc_sat)
  );

  // ---- stimulus drivers (no checking; lat=20 signals a timeout) ----
  task automatic offer_a(input logic [11:0] bits, input logic mode, output int lat);
    int k;
    k = 0;
    a_in_bits = bits; a_in_mode = mode; a_in_valid = 1'b1;
    while (!a_in_ready && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    lat = 0;
    while (!a_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_a();
    $display("txn A: bits=%03h mode=%0d count=%0d", a_in_bits, a_in_mode, a_out_count);
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
  endtask

  task automatic offer_b(input logic [9:0] bits, input logic mode, output int lat);
    int k;
    k = 0;
    b_in_bits = bits; b_in_mode = mode; b_in_valid = 1'b1;
    while (!b_in_ready && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_b();
    $display("txn B: bits=%03h mode=%0d count=%0d", b_in_bits, b_in_mode, b_out_count);
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    b_out_ready = 1'b0;
  endtask

  task automatic offer_c(input logic [11:0] bits, input logic mode, output int lat);
    int k;
    k = 0;
    c_in_bits = bits; c_in_mode = mode; c_in_valid = 1'b1;
    while (!c_in_ready && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    lat = 0;
    while (!c_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic take_c(input logic clr);
    $display("txn C: bits=%03h mode=%0d count=%0d clr=%0d", c_in_bits, c_in_mode, c_out_count, clr);
    c_out_ready = 1'b1;
    c_acc_clr   = clr;
    @(posedge clk); #1;
    c_out_ready = 1'b0;
    c_acc_clr   = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", a_in_ready); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_count !== 4'd0) $display("FAIL reset_out_count: got %0d want 0", a_out_count); else n_pass++;
    n_checks++; if (a_acc_total !== 16'd0) $display("FAIL reset_acc_total: got %0d want 0", a_acc_total); else n_pass++;
    n_checks++; if (a_acc_sat !== 1'b0) $display("FAIL reset_acc_sat: got %0b want 0", a_acc_sat); else n_pass++;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL post_reset_in_ready: got %0b want 1", a_in_ready); else n_pass++;
    n_checks++; if (c_acc_total !== 4'd0) $display("FAIL post_reset_c_acc: got %0d want 0", c_acc_total); else n_pass++;
  endtask

  task automatic test_ones_fff();
    int lat;
    a_out_ready = 1'b1;
    offer_a(12'hFFF, 1'b0, lat);
    n_checks++; if (lat !== 3) $display("FAIL fff_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (a_out_count !== 4'd12) $display("FAIL fff_count: got %0d want 12", a_out_count); else n_pass++;
    take_a();
    n_checks++; if (a_acc_total !== 16'd12) $display("FAIL fff_acc_total: got %0d want 12", a_acc_total); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL fff_in_ready_back: got %0b want 1", a_in_ready); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL fff_out_valid_drop: got %0b want 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_ones_zeros();
    int lat;
    offer_a(12'b010110101101, 1'b0, lat);
    n_checks++; if (lat !== 3) $display("FAIL ones_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (a_out_count !== 4'd7) $display("FAIL ones_count: got %0d want 7", a_out_count); else n_pass++;
    take_a();
    offer_a(12'b100001011100, 1'b1, lat);
    n_checks++; if (a_out_count !== 4'd7) $display("FAIL zeros_count: got %0d want 7", a_out_count); else n_pass++;
    take_a();
    n_checks++; if (a_acc_total !== 16'd26) $display("FAIL ones_zeros_acc: got %0d want 26", a_acc_total); else n_pass++;
  endtask

  task automatic test_backpressure();
    int lat;
    offer_a(12'b010110101101, 1'b0, lat);
    n_checks++; if (lat !== 3) $display("FAIL bp_latency: got %0d want 3", lat); else n_pass++;
    a_in_bits  = 12'h000;
    a_in_mode  = 1'b1;
    a_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++; if (a_out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, a_out_valid); else n_pass++;
      n_checks++; if (a_out_count !== 4'd7) $display("FAIL bp_out_count[%0d]: got %0d want 7", i, a_out_count); else n_pass++;
      n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, a_in_ready); else n_pass++;
      n_checks++; if (a_acc_total !== 16'd26) $display("FAIL bp_acc_hold[%0d]: got %0d want 26", i, a_acc_total); else n_pass++;
    end
    a_in_valid = 1'b0;
    a_in_bits  = 12'b010110101101;
    a_in_mode  = 1'b0;
    take_a();
    n_checks++; if (a_acc_total !== 16'd33) $display("FAIL bp_acc_after: got %0d want 33", a_acc_total); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL bp_no_extra_word: got %0b want 0", a_out_valid); else n_pass++;
  endtask

  task automatic test_width10_padding();
    int lat;
    offer_b(10'h000, 1'b1, lat);
    n_checks++; if (lat !== 3) $display("FAIL w10_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (b_out_count !== 4'd10) $display("FAIL w10_zeros_count: got %0d want 10", b_out_count); else n_pass++;
    take_b();
    offer_b(10'h3FF, 1'b0, lat);
    n_checks++; if (b_out_count !== 4'd10) $display("FAIL w10_ones_count: got %0d want 10", b_out_count); else n_pass++;
    take_b();
    n_checks++; if (b_acc_total !== 16'd20) $display("FAIL w10_acc: got %0d want 20", b_acc_total); else n_pass++;
  endtask

  task automatic test_acc_saturation();
    int lat;
    offer_c(12'hFFF, 1'b0, lat);
    take_c(1'b0);
    n_checks++; if (c_acc_total !== 4'd12) $display("FAIL sat_first_acc: got %0d want 12", c_acc_total); else n_pass++;
    n_checks++; if (c_acc_sat !== 1'b0) $display("FAIL sat_first_flag: got %0b want 0", c_acc_sat); else n_pass++;
    offer_c(12'h0FF, 1'b0, lat);
    n_checks++; if (c_out_count !== 4'd8) $display("FAIL sat_second_count: got %0d want 8", c_out_count); else n_pass++;
    take_c(1'b0);
    n_checks++; if (c_acc_total !== 4'd15) $display("FAIL sat_clamp_acc: got %0d want 15", c_acc_total); else n_pass++;
    n_checks++; if (c_acc_sat !== 1'b1) $display("FAIL sat_clamp_flag: got %0b want 1", c_acc_sat); else n_pass++;
    offer_c(12'h001, 1'b0, lat);
    take_c(1'b0);
    n_checks++; if (c_acc_total !== 4'd15) $display("FAIL sat_hold_acc: got %0d want 15", c_acc_total); else n_pass++;
    n_checks++; if (c_acc_sat !== 1'b1) $display("FAIL sat_sticky_flag: got %0b want 1", c_acc_sat); else n_pass++;
    offer_c(12'h01F, 1'b0, lat);
    n_checks++; if (c_out_count !== 4'd5) $display("FAIL clr_hs_count: got %0d want 5", c_out_count); else n_pass++;
    take_c(1'b1);
    n_checks++; if (c_acc_total !== 4'd5) $display("FAIL clr_hs_acc: got %0d want 5", c_acc_total); else n_pass++;
    n_checks++; if (c_acc_sat !== 1'b0) $display("FAIL clr_hs_flag: got %0b want 0", c_acc_sat); else n_pass++;
    c_acc_clr = 1'b1;
    @(posedge clk); #1;
    c_acc_clr = 1'b0;
    n_checks++; if (c_acc_total !== 4'd0) $display("FAIL clr_alone_acc: got %0d want 0", c_acc_total); else n_pass++;
  endtask

  task automatic test_reset_busy();
    int lat;
    bit seen_valid;
    a_in_bits = 12'hFFF; a_in_mode = 1'b0; a_in_valid = 1'b1;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL rstbusy_in_ready: got %0b want 1", a_in_ready); else n_pass++;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rstbusy_out_valid: got %0b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_acc_total !== 16'd0) $display("FAIL rstbusy_acc_total: got %0d want 0", a_acc_total); else n_pass++;
    n_checks++; if (a_out_count !== 4'd0) $display("FAIL rstbusy_out_count: got %0d want 0", a_out_count); else n_pass++;
    n_checks++; if (b_acc_total !== 16'd0) $display("FAIL rstbusy_b_acc: got %0d want 0", b_acc_total); else n_pass++;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen_valid = 1'b1;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (a_out_valid) seen_valid = 1'b1;
    end
    n_checks++; if (seen_valid !== 1'b0) $display("FAIL rstbusy_no_pulse: got %0b want 0", seen_valid); else n_pass++;
    offer_a(12'b010110101101, 1'b0, lat);
    n_checks++; if (lat !== 3) $display("FAIL rstbusy_next_latency: got %0d want 3", lat); else n_pass++;
    n_checks++; if (a_out_count !== 4'd7) $display("FAIL rstbusy_next_count: got %0d want 7", a_out_count); else n_pass++;
    take_a();
    n_checks++; if (a_acc_total !== 16'd7) $display("FAIL rstbusy_next_acc: got %0d want 7", a_acc_total); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit reached want normal finish");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_ones_fff();
    test_ones_zeros();
    test_backpressure();
    test_width10_padding();
    test_acc_saturation();
    test_reset_busy();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
